// File: rtl/vdp_seq_pkg.sv
// Shared types and sizing for the VDP port sequencer.
// VDP_SEQ_FIFO_EN selects a 4-deep command FIFO; otherwise a single holding register is used.
package vdp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RECOVER = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic       wr;
        logic       mode;
        logic [7:0] data;
    } seq_cmd_t;

`ifdef VDP_SEQ_FIFO_EN
    localparam int FIFO_DEPTH = 4;
`else
    localparam int FIFO_DEPTH = 1;
`endif

endpackage

// File: rtl/vdp_seq_fifo.sv
// In-order command FIFO with show-ahead head output; depth 1 collapses to a holding register.
module vdp_seq_fifo
    import vdp_seq_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
)
(
    input  logic     clk,
    input  logic     RESET,
    input  logic     i_push,
    input  seq_cmd_t i_din,
    input  logic     i_pop,
    output seq_cmd_t o_dout,
    output logic     o_full,
    output logic     o_empty
);

    logic w_push;
    logic w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    if (DEPTH == 1) begin : g_hold
        logic     r_valid;
        seq_cmd_t r_cmd;

        always_ff @(posedge clk) begin
            if (RESET) begin
                r_valid <= 1'b0;
                r_cmd   <= '0;
            end else if (w_push) begin
                r_valid <= 1'b1;
                r_cmd   <= i_din;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end

        assign o_full  = r_valid;
        assign o_empty = !r_valid;
        assign o_dout  = r_cmd;
    end else begin : g_ring
        localparam int PW = $clog2(DEPTH);
        localparam int CW = $clog2(DEPTH + 1);

        seq_cmd_t      r_mem [DEPTH];
        logic [PW-1:0] r_wr_ptr;
        logic [PW-1:0] r_rd_ptr;
        logic [CW-1:0] r_count;

        always_ff @(posedge clk) begin
            if (RESET) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
                if (w_pop)
                    r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
                // Simultaneous push and pop leaves the occupancy unchanged.
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (w_push)
                r_mem[r_wr_ptr] <= i_din;
        end

        assign o_full  = (r_count == CW'(DEPTH));
        assign o_empty = (r_count == '0);
        assign o_dout  = r_mem[r_rd_ptr];
    end

endmodule

// File: rtl/vdp_port_sequencer.sv
// Sequences queued read/write commands onto the VDP CPU port with setup/strobe/recovery timing.
// Command queue depth is 4 with VDP_SEQ_FIFO_EN defined, otherwise a single holding register.
module vdp_port_sequencer
    import vdp_seq_pkg::*;
#(
    parameter int SETUP_CYC    = 2,
    parameter int STROBE_CYC   = 6,
    parameter int RECOVERY_CYC = 8
)
(
    input  logic       clk,
    input  logic       RESET,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic       req_mode,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       vdp_csr_n,
    output logic       vdp_csw_n,
    output logic       vdp_mode,
    output logic [0:7] vdp_cd_o,
    input  logic [0:7] vdp_cd_i
);

    seq_cmd_t   w_din;
    seq_cmd_t   w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_capture;
    seq_state_t r_state;
    seq_state_t w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       r_wr;
    logic       r_mode;
    logic [7:0] r_cd;
    logic       r_csr_n;
    logic       r_csw_n;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_data;

    assign w_din = '{wr: req_wr, mode: req_mode, data: req_data};

    vdp_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .RESET   (RESET),
        .i_push  (req_valid),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = SETUP;
                    w_cnt_next   = 8'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = STROBE;
                    w_cnt_next   = 8'(STROBE_CYC - 1);
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            STROBE: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = RECOVER;
                    w_cnt_next   = 8'(RECOVERY_CYC - 1);
                    w_capture    = !r_wr;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            RECOVER: begin
                if (r_cnt == 8'd0)
                    w_state_next = IDLE;
                else
                    w_cnt_next = r_cnt - 1'b1;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_wr        <= 1'b0;
            r_mode      <= 1'b0;
            r_cd        <= 8'd0;
            r_csr_n     <= 1'b1;
            r_csw_n     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_pop) begin
                r_wr   <= w_head.wr;
                r_mode <= w_head.mode;
                r_cd   <= w_head.data;
            end
            // Strobes are registered from the next state so they are glitch-free at the pins.
            r_csw_n     <= !((w_state_next == STROBE) && r_wr);
            r_csr_n     <= !((w_state_next == STROBE) && !r_wr);
            r_rsp_valid <= w_capture;
            if (w_capture)
                r_rsp_data <= vdp_cd_i;
        end
    end

    assign req_ready = !w_full;
    assign busy      = !w_empty || (r_state != IDLE);
    assign vdp_csr_n = r_csr_n;
    assign vdp_csw_n = r_csw_n;
    assign vdp_mode  = r_mode;
    assign vdp_cd_o  = r_cd;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_vdp_port_sequencer.sv
// Scoreboard bench for vdp_port_sequencer: commands are queued on acceptance and checked at strobe/response time.
module tb_vdp_port_sequencer;
    import vdp_seq_pkg::*;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_wr = 1'b0;
    logic       req_mode = 1'b0;
    logic [7:0] req_data = 8'd0;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       vdp_csr_n;
    logic       vdp_csw_n;
    logic       vdp_mode;
    logic [7:0] vdp_cd_o;
    logic [7:0] vdp_cd_i = 8'd0;

    vdp_port_sequencer dut (
        .clk       (clk),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_mode  (req_mode),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .vdp_csr_n (vdp_csr_n),
        .vdp_csw_n (vdp_csw_n),
        .vdp_mode  (vdp_mode),
        .vdp_cd_o  (vdp_cd_o),
        .vdp_cd_i  (vdp_cd_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_no = 0;
    int rsp_cnt = 0;
    bit abort_access = 1'b0;

    seq_cmd_t   sb_cmd[$];
    logic [7:0] sb_rsp[$];
    int         fall_edges[$];

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    // Monitor: sampled on the falling clock edge, away from the active edge.
    initial begin
        logic     prev_csw = 1'b1;
        logic     prev_csr = 1'b1;
        logic     prev_rv = 1'b0;
        logic     cur_wr = 1'b0;
        int       fall_at = 0;
        seq_cmd_t e;
        forever begin
            @(negedge clk);
            if (!vdp_csw_n && !vdp_csr_n)
                check_eq("both_strobes_low", {31'd0, vdp_csw_n | vdp_csr_n}, 32'd1);
            if ((!vdp_csw_n && prev_csw) || (!vdp_csr_n && prev_csr)) begin
                if (sb_cmd.size() == 0) begin
                    check_eq("unexpected_strobe", sb_cmd.size(), 32'd1);
                end else begin
                    e = sb_cmd.pop_front();
                    check_eq("strobe_is_write", {31'd0, !vdp_csw_n}, {31'd0, e.wr});
                    check_eq("vdp_mode", {31'd0, vdp_mode}, {31'd0, e.mode});
                    check_eq("vdp_cd_o", {24'd0, vdp_cd_o}, {24'd0, e.data});
                end
                fall_edges.push_back(edge_no);
                fall_at = edge_no;
                cur_wr  = !vdp_csw_n;
            end
            if ((vdp_csw_n && !prev_csw) || (vdp_csr_n && !prev_csr)) begin
                if (abort_access) begin
                    abort_access = 1'b0;
                end else begin
                    check_eq("strobe_len", edge_no - fall_at, 32'd6);
                    if (!cur_wr)
                        check_eq("rsp_at_strobe_rise", {31'd0, rsp_valid}, 32'd1);
                end
            end
            if (rsp_valid) begin
                $display("rsp  edge=%0d data=0x%02h", edge_no, rsp_data);
                if (prev_rv)
                    check_eq("rsp_pulse_width", {31'd0, prev_rv}, 32'd0);
                if (sb_rsp.size() == 0)
                    check_eq("spurious_rsp", sb_rsp.size(), 32'd1);
                else
                    check_eq("rsp_data", {24'd0, rsp_data}, {24'd0, sb_rsp.pop_front()});
                rsp_cnt++;
            end
            prev_csw = vdp_csw_n;
            prev_csr = vdp_csr_n;
            prev_rv  = rsp_valid;
        end
    end

    task automatic send(input logic wr, input logic mode, input logic [7:0] d,
                        input logic [7:0] rd_exp, output int acc);
        int n = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_mode  = mode;
        req_data  = d;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready)
            check_eq("ready_timeout", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        sb_cmd.push_back('{wr: wr, mode: mode, data: d});
        if (!wr)
            sb_rsp.push_back(rd_exp);
        @(negedge clk);
        acc = edge_no;
        req_valid = 1'b0;
        $display("req  edge=%0d wr=%0d mode=%0d data=0x%02h", acc, wr, mode, d);
    endtask

    task automatic wait_until(input int k);
        while (edge_no < k)
            @(negedge clk);
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n = 0;
        while (rsp_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (rsp_cnt < target)
            check_eq("rsp_timeout", rsp_cnt, target);
    endtask

    task automatic wait_falls(input int target, input int budget);
        int n = 0;
        while (fall_edges.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (fall_edges.size() < target)
            check_eq("strobe_timeout", fall_edges.size(), target);
    endtask

    task automatic check_gaps(input string tag, input int first, input int count);
        for (int i = 1; i < count; i++) begin
            if (fall_edges.size() > first + i)
                check_eq(tag, fall_edges[first + i] - fall_edges[first + i - 1], 32'd17);
            else
                check_eq({tag, "_missing"}, fall_edges.size(), first + count);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a, b, r0, nf, first_low, first_high, bad, csr_low;

        repeat (3) @(negedge clk);
        check_eq("rst_csr_n", {31'd0, vdp_csr_n}, 32'd1);
        check_eq("rst_csw_n", {31'd0, vdp_csw_n}, 32'd1);
        check_eq("rst_mode", {31'd0, vdp_mode}, 32'd0);
        check_eq("rst_cd_o", {24'd0, vdp_cd_o}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        RESET = 1'b0;
        @(negedge clk);

        // Single write: strobe edges and held bus.
        send(1'b1, 1'b1, 8'h81, 8'h00, a);
        first_low = -1; first_high = -1; bad = 0; csr_low = 0;
        while (edge_no <= a + 18) begin
            if (edge_no >= a + 1 && edge_no <= a + 17 && (vdp_cd_o !== 8'h81 || vdp_mode !== 1'b1))
                bad++;
            if (!vdp_csw_n && first_low < 0)
                first_low = edge_no;
            if (vdp_csw_n && first_low >= 0 && first_high < 0)
                first_high = edge_no;
            if (!vdp_csr_n)
                csr_low++;
            @(negedge clk);
        end
        check_eq("wr_fall_edge", first_low - a, 32'd3);
        check_eq("wr_rise_edge", first_high - a, 32'd9);
        check_eq("wr_bus_hold_bad_cycles", bad, 32'd0);
        check_eq("wr_csr_low_cycles", csr_low, 32'd0);

        // Single read returning 0x9F.
        vdp_cd_i = 8'h9F;
        r0 = rsp_cnt;
        send(1'b0, 1'b1, 8'h00, 8'h9F, a);
        wait_rsp(r0 + 1, 60);
        wait_until(a + 20);
        check_eq("rd_rsp_count", rsp_cnt - r0, 32'd1);

        // Write 0x00 immediately followed by a read.
        vdp_cd_i = 8'h3C;
        r0 = rsp_cnt;
        nf = fall_edges.size();
        send(1'b1, 1'b0, 8'h00, 8'h00, a);
        send(1'b0, 1'b0, 8'h00, 8'h3C, b);
        wait_rsp(r0 + 1, 80);
        wait_until(edge_no + 20);
        check_eq("wr_rd_rsp_count", rsp_cnt - r0, 32'd1);
        check_gaps("wr_rd_gap", nf, 2);

`ifdef VDP_SEQ_FIFO_EN
        // Burst of five writes behind an access already in flight.
        nf = fall_edges.size();
        send(1'b1, 1'b0, 8'h11, 8'h00, a);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, i[0], 8'hA0 + 8'(i), 8'h00, a);
            if (i == 3)
                check_eq("ready_after_4th", {31'd0, req_ready}, 32'd0);
        end
        wait_falls(nf + 6, 150);
        wait_until(edge_no + 18);
        check_gaps("burst_gap", nf, 6);
`else
        // Holding register: second request waits for the first pop.
        nf = fall_edges.size();
        send(1'b1, 1'b0, 8'h55, 8'h00, a);
        check_eq("ready_held", {31'd0, req_ready}, 32'd0);
        send(1'b1, 1'b1, 8'h66, 8'h00, b);
        check_eq("second_accept_delay", b - a, 32'd2);
        wait_falls(nf + 2, 60);
        wait_until(edge_no + 18);
        check_gaps("hold_gap", nf, 2);
`endif

        // Reset in the middle of a read strobe.
        vdp_cd_i = 8'hE7;
        send(1'b0, 1'b1, 8'h00, 8'hE7, a);
        wait_until(a + 5);
        check_eq("csr_low_before_reset", {31'd0, vdp_csr_n}, 32'd0);
        abort_access = 1'b1;
        RESET = 1'b1;
        @(negedge clk);
        check_eq("midrst_csr_n", {31'd0, vdp_csr_n}, 32'd1);
        check_eq("midrst_csw_n", {31'd0, vdp_csw_n}, 32'd1);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("midrst_mode", {31'd0, vdp_mode}, 32'd0);
        check_eq("midrst_cd_o", {24'd0, vdp_cd_o}, 32'd0);
        RESET = 1'b0;
        sb_rsp.delete();
        r0 = rsp_cnt;
        repeat (20) @(negedge clk);
        check_eq("no_rsp_after_reset", rsp_cnt - r0, 32'd0);

        send(1'b1, 1'b1, 8'h5A, 8'h00, a);
        wait_until(a + 18);
        check_eq("post_reset_fall_edge", fall_edges[$] - a, 32'd3);

        check_eq("cmd_queue_drained", sb_cmd.size(), 32'd0);
        check_eq("rsp_queue_drained", sb_rsp.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vdp_port_sequencer.md
VDP_PORT_SEQUENCER -- requirements
Module: vdp_port_sequencer

Interface
REQ-001 SHALL provide parameter: SETUP_CYC, 2, clk cycles mode/data are stable before the strobe falls (legal range 1..255).
REQ-002 SHALL provide parameter: STROBE_CYC, 6, clk cycles csr_n/csw_n are held low (legal range 1..255).
REQ-003 SHALL provide parameter: RECOVERY_CYC, 8, clk cycles strobes stay high, with mode/data held, after the strobe rises (legal range 1..255).
REQ-004 SHALL provide ports:
  clk  in  1  clock.
  RESET  in  1  reset, synchronous, active-high.
  req_valid  in  1  command offered.
  req_ready  out  1  command accepted when req_valid && req_ready.
  req_wr  in  1  1=write, 0=read.
  req_mode  in  1  VDP mode (0=data port, 1=control/status port).
  req_data  in  8  write data.
  rsp_valid  out  1  one-cycle pulse: read data available.
  rsp_data  out  8  read data.
  busy  out  1  FIFO non-empty or FSM not IDLE.
  vdp_csr_n  out  1  VDP read strobe.
  vdp_csw_n  out  1  VDP write strobe.
  vdp_mode  out  1  VDP mode.
  vdp_cd_o  out  8  data to VDP cd_i.
  vdp_cd_i  in  8  data from VDP cd_o.
REQ-005 SHALL map req_data[7] and rsp_data[7] to VDP bus bit 0 (MSB-first VDP numbering).

Function
REQ-006 SHALL queue accepted commands {wr, mode, data} in an in-order command FIFO; reads and writes share it, and reads never bypass writes.
REQ-007 SHALL drive req_ready = !fifo_full; there is no same-cycle pop credit when the FIFO is full.
REQ-008 SHALL run an FSM with states IDLE, SETUP, STROBE, RECOVER.
REQ-009 SHALL, in IDLE with the FIFO non-empty, pop the head command, load vdp_mode and vdp_cd_o, and enter SETUP at the same edge.
REQ-010 SHALL go SETUP -> STROBE after SETUP_CYC cycles, STROBE -> RECOVER after STROBE_CYC cycles, and RECOVER -> IDLE after RECOVERY_CYC cycles, using an 8-bit down-counter.
REQ-011 SHALL hold the strobe low only in STROBE: vdp_csw_n for writes, vdp_csr_n for reads; both strobes are never low together.
REQ-012 SHALL, for a command pushed at edge N into an empty FIFO with FSM IDLE, drive the strobe low at edge N+1+SETUP_CYC and high at edge N+1+SETUP_CYC+STROBE_CYC.
REQ-013 SHALL, for a read, register vdp_cd_i into rsp_data at the edge leaving STROBE and pulse rsp_valid for exactly the following cycle.
REQ-014 SHALL hold rsp_data until the next read capture.
REQ-015 SHALL hold vdp_mode/vdp_cd_o constant from SETUP entry until RECOVER exit; they keep their last values while IDLE.
REQ-016 SHALL, when a push and a pop occur in the same cycle on a non-full FIFO, perform both and leave the count unchanged.
REQ-017 SHALL pop the next command in the IDLE cycle immediately after RECOVER, so back-to-back accesses are spaced 1+SETUP_CYC+STROBE_CYC+RECOVERY_CYC cycles.

Reset
REQ-018 SHALL, on RESET at any edge (including mid-access), force vdp_csr_n=1, vdp_csw_n=1, vdp_mode=0, vdp_cd_o=0, rsp_valid=0, rsp_data=0, and state IDLE.
REQ-019 SHALL, on RESET, flush the FIFO so that req_ready=1 and busy=0, and a read interrupted by RESET produces no rsp_valid.

Configuration
REQ-020 SHALL, with VDP_SEQ_FIFO_EN defined, use a command FIFO of depth 4.
REQ-021 SHALL, without VDP_SEQ_FIFO_EN, use a depth-1 holding register; req_ready=1 only when that register is empty, and all other timing is identical.

Structure
REQ-022 SHALL place the FSM state enum, the command struct typedef {wr, mode, data[7:0]} and the FIFO depth constant in package vdp_seq_pkg.
REQ-023 SHALL implement the FIFO as sub-module vdp_seq_fifo, parameterised by depth, with push/pop/full/empty ports.

Verification
REQ-024 Bench SHALL cover: write mode=1 data=0x81 at edge 0 (defaults) -> vdp_csw_n low edges 3..9, vdp_cd_o=0x81 and vdp_mode=1 over edges 1..17, vdp_csr_n stays 1.
REQ-025 Bench SHALL cover: read mode=1 with vdp_cd_i=0x9F -> vdp_csr_n low for 6 cycles, then rsp_valid high for 1 cycle with rsp_data=0x9F.
REQ-026 Bench SHALL cover: 5 back-to-back writes with VDP_SEQ_FIFO_EN -> req_ready low after the 4th acceptance; strobe falling edges 17 cycles apart; data order preserved.
REQ-027 Bench SHALL cover: write 0x00, then read, with no gap -> the read strobe falls 17 cycles after the write strobe falls, and exactly one rsp_valid.
REQ-028 Bench SHALL cover: RESET asserted for 1 cycle during STROBE of a read -> strobes high at that edge, busy=0, no rsp_valid; the next command executes normally.
REQ-029 Bench SHALL cover: without VDP_SEQ_FIFO_EN, a second request is held off (req_ready=0) until the first command is popped.
